cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter N_REQ, default 2, is the number of functional-unit requesters (N_ALU + N_MUL); index 0..N_ALU-1 are ALUs, the rest are MULs.
REQ-003 Parameter VAL_W, default 32, is the result value width.
REQ-004 Parameter ROB_W, default 8, is the ROB ID width.
REQ-005 Parameter PREG_W, default 6 ($clog2(TABLE_ENTRIES)), is the physical destination register width.
REQ-006 clk  input  1  clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 flush  input  1  mispredict flush; discards all buffered and in-flight results.
REQ-009 req_valid  input  N_REQ  per-FU result valid (fu_output_t.ready_for_writeback).
REQ-010 req_value  input  N_REQ x VAL_W  per-FU result value.
REQ-011 req_rob_id  input  N_REQ x ROB_W  per-FU ROB ID.
REQ-012 req_prd  input  N_REQ x PREG_W  per-FU physical destination.
REQ-013 req_ready  output  N_REQ  arbiter can accept that FU's result this cycle.
REQ-014 cdb_valid  output  1  registered broadcast valid.
REQ-015 cdb_value / cdb_rob_id / cdb_prd  output  VAL_W / ROB_W / PREG_W  registered broadcast payload.
REQ-016 cdb_src  output  $clog2(N_REQ)  index of the requester that produced the broadcast.

Function
REQ-017 Each requester SHALL own a one-entry holding slot (slot_valid, payload).
REQ-018 req_ready[i] SHALL equal !flush && (!slot_valid[i] || grant[i]), combinationally.
REQ-019 Accept: req_valid[i] && req_ready[i] at an edge loads slot i; req_valid without req_ready loads nothing, and the FU holds its output.
REQ-020 Grant is combinational over slot_valid only; at most one grant per cycle. Incoming requests do not bypass the slot.
REQ-021 Round-robin: grant the first valid slot at index rr_ptr, rr_ptr+1, ..., wrapping mod N_REQ.
REQ-022 rr_ptr SHALL update to (g+1) mod N_REQ after a grant to g, and hold when there is no grant.
REQ-023 Granted slot g: at the edge, cdb_* loads slot g's payload, cdb_src is set to g, and cdb_valid goes to 1. Slot g clears unless it is reloaded the same edge.
REQ-024 No grant: cdb_valid SHALL be 0 next cycle; the cdb payload holds its last value.
REQ-025 Latency: a result accepted at edge k SHALL appear on cdb no earlier than the cycle after edge k+1, and exactly then if granted at k+1.
REQ-026 Throughput: a single active requester SHALL sustain one broadcast per cycle (grant and reload on the same edge).
REQ-027 Fairness: a valid slot SHALL be granted within N_REQ cycles of becoming valid.
REQ-028 flush at an edge SHALL clear all slot_valid, set cdb_valid to 0, and reset rr_ptr to 0. Same-cycle requests are not accepted.
REQ-029 The cdb register SHALL always consume (no downstream backpressure). The register file and reservation stations sample cdb_valid each cycle.

Reset
REQ-030 While rst_n=0, the block SHALL force: slot_valid all 0, payloads 0, rr_ptr 0, cdb_valid 0, cdb_value/rob_id/prd/src 0, req_ready all 0.
REQ-031 Reset assertion mid-operation SHALL drop buffered results immediately, without waiting for clk.
REQ-032 After rst_n rises, req_ready SHALL be all 1 (slots empty) on the first cycle.

Verification
REQ-033 Single request: FU0 asserts value=0xDEADBEEF, rob=3, prd=17 for one cycle at edge 1 -> cdb_valid=1 with 0xDEADBEEF/3/17, src=0 in the cycle after edge 2, then cdb_valid=0.
REQ-034 Contention: FU0 and FU1 both valid every cycle from reset -> cdb_src alternates 0,1,0,1 after edge 2. Each FU sees req_ready toggle, and no result is lost or duplicated (check by ROB ID).
REQ-035 Streaming: only FU1 valid for 8 cycles with rob 0..7 -> 8 consecutive cdb_valid cycles, rob 0..7 in order, and req_ready[1] constantly 1.
REQ-036 Flush: both slots full, flush=1 for one cycle -> next cycle cdb_valid=0, req_ready=2'b11, rr_ptr=0. The flushed ROB IDs never appear on the cdb.
REQ-037 Async reset: assert rst_n=0 between clock edges with slots full -> cdb_valid and req_ready go 0 before the next edge. Nothing is broadcast after release until new requests arrive.
REQ-038 Random: random req_valid/backpressure for 10k cycles -> scoreboard confirms every accepted result is broadcast exactly once, with no grant wait exceeding N_REQ cycles.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, round-robin
// grant over the occupied slots, and a registered single-result broadcast.
module cdb_arbiter #(
  parameter int N_REQ  = 2,
  parameter int VAL_W  = 32,
  parameter int ROB_W  = 8,
  parameter int PREG_W = 6,
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0][VAL_W-1:0]   req_value,
  input  logic [N_REQ-1:0][ROB_W-1:0]   req_rob_id,
  input  logic [N_REQ-1:0][PREG_W-1:0]  req_prd,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          cdb_valid,
  output logic [VAL_W-1:0]              cdb_value,
  output logic [ROB_W-1:0]              cdb_rob_id,
  output logic [PREG_W-1:0]             cdb_prd,
  output logic [SRC_W-1:0]              cdb_src
);

  logic [N_REQ-1:0]              slot_valid;
  logic [N_REQ-1:0][VAL_W-1:0]   slot_value;
  logic [N_REQ-1:0][ROB_W-1:0]   slot_rob_id;
  logic [N_REQ-1:0][PREG_W-1:0]  slot_prd;
  logic [SRC_W-1:0]              rr_ptr;

  logic [N_REQ-1:0]              grant;
  logic                          any_grant;
  logic [SRC_W-1:0]              grant_idx;
  logic [SRC_W-1:0]              next_ptr;

  // Round-robin search starting at rr_ptr; only buffered slots compete, so a
  // fresh request always spends at least one cycle in its slot.
  always_comb begin
    int idx;
    grant     = '0;
    any_grant = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_grant && slot_valid[SRC_W'(idx)]) begin
        any_grant = 1'b1;
        grant_idx = SRC_W'(idx);
        grant     = N_REQ'(1) << idx;
      end
    end
    next_ptr = (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Handshake: a result transfers on a rising edge where req_valid[i] and
  // req_ready[i] are both high; with ready low the FU keeps its output stable.
  // Ready is offered when the slot is empty or is draining this very cycle.
  assign req_ready = (rst_n && !flush) ? (~slot_valid | grant) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid  <= '0;
      slot_value  <= '0;
      slot_rob_id <= '0;
      slot_prd    <= '0;
      rr_ptr      <= '0;
      cdb_valid   <= 1'b0;
      cdb_value   <= '0;
      cdb_rob_id  <= '0;
      cdb_prd     <= '0;
      cdb_src     <= '0;
    end else if (flush) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
      cdb_valid  <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          slot_valid[i]  <= 1'b1;
          slot_value[i]  <= req_value[i];
          slot_rob_id[i] <= req_rob_id[i];
          slot_prd[i]    <= req_prd[i];
        end else if (grant[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
      cdb_valid <= any_grant;
      if (any_grant) begin
        cdb_value  <= slot_value[grant_idx];
        cdb_rob_id <= slot_rob_id[grant_idx];
        cdb_prd    <= slot_prd[grant_idx];
        cdb_src    <= grant_idx;
        rr_ptr     <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus a randomized run checked
// against a slot/round-robin reference model and an accepted-result scoreboard.
module tb_cdb_arbiter;

  localparam int N  = 2;
  localparam int VW = 32;
  localparam int RW = 8;
  localparam int PW = 6;
  localparam int SW = 1;
  localparam int PL = RW + PW + VW;
  localparam int W  = SW + PL;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush = 1'b0;
  logic [N-1:0]           req_valid = '0;
  logic [N-1:0][VW-1:0]   req_value = '0;
  logic [N-1:0][RW-1:0]   req_rob_id = '0;
  logic [N-1:0][PW-1:0]   req_prd = '0;
  logic [N-1:0]           req_ready;
  logic                   cdb_valid;
  logic [VW-1:0]          cdb_value;
  logic [RW-1:0]          cdb_rob_id;
  logic [PW-1:0]          cdb_prd;
  logic [SW-1:0]          cdb_src;

  cdb_arbiter #(.N_REQ(N), .VAL_W(VW), .ROB_W(RW), .PREG_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_value(req_value), .req_rob_id(req_rob_id),
    .req_prd(req_prd), .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_rob_id(cdb_rob_id),
    .cdb_prd(cdb_prd), .cdb_src(cdb_src)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  // reference model: occupied slots, their payloads, rotating priority start
  logic          m_occ[N];
  logic [PL-1:0] m_slot[N];
  int            m_ptr;
  logic          m_cv;
  logic [W-1:0]  m_cdb;

  // scoreboard of accepted-but-not-yet-broadcast results
  logic [W-1:0] exp_q[$];
  int           acc_q[$];

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int idx = (m_ptr + k) % N;
      if (m_occ[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (rst_n && !flush)
      for (int i = 0; i < N; i++) r[i] = !m_occ[i] || (g == i);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_occ[i]  = 1'b0;
      m_slot[i] = '0;
    end
    m_ptr = 0;
    m_cv  = 1'b0;
    m_cdb = '0;
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic model_edge();
    logic [N-1:0] r;
    int g;
    r = model_ready();
    g = model_grant();
    if (flush) begin
      for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
      m_cv  = 1'b0;
      m_ptr = 0;
      exp_q.delete();
      acc_q.delete();
    end else begin
      if (g >= 0) begin
        m_cv      = 1'b1;
        m_cdb     = {SW'(g), m_slot[g]};
        m_occ[g]  = 1'b0;
        m_ptr     = (g + 1) % N;
      end else begin
        m_cv = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && r[i]) begin
          m_occ[i]  = 1'b1;
          m_slot[i] = {req_rob_id[i], req_prd[i], req_value[i]};
          exp_q.push_back({SW'(i), m_slot[i]});
          acc_q.push_back(cyc + 1);
        end
      end
    end
  endtask

  // driver tasks
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    flush      = 1'b0;
    req_valid  = '0;
    req_value  = '0;
    req_rob_id = '0;
    req_prd    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    vectors++;
    if (cdb_valid !== 1'b0 || req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_hold: cdb_valid=%b req_ready=%b, want 0/00", cdb_valid, req_ready);
    end
    vectors++;
    if (cdb_value !== '0 || cdb_rob_id !== '0 || cdb_prd !== '0 || cdb_src !== '0) begin
      miscompares++;
      $display("FAIL reset_payload: val=%h rob=%h prd=%h src=%h, want all 0",
               cdb_value, cdb_rob_id, cdb_prd, cdb_src);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_release_ready: req_ready=%b, want 11", req_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid[0]  = 1'b1;
    req_value[0]  = 32'hDEADBEEF;
    req_rob_id[0] = 8'd3;
    req_prd[0]    = 6'd17;
    step();
    req_valid = '0;
    vectors++;
    if (cdb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_no_bypass: cdb_valid=%b after edge 1, want 0", cdb_valid);
    end
    step();
    vectors++;
    if (cdb_valid !== 1'b1 || cdb_value !== 32'hDEADBEEF || cdb_rob_id !== 8'd3 ||
        cdb_prd !== 6'd17 || cdb_src !== 1'b0) begin
      miscompares++;
      $display("FAIL single_bcast: v=%b val=%h rob=%0d prd=%0d src=%0d, want 1/deadbeef/3/17/0",
               cdb_valid, cdb_value, cdb_rob_id, cdb_prd, cdb_src);
    end
    step();
    vectors++;
    if (cdb_valid !== 1'b0 || cdb_value !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL single_idle: v=%b val=%h, want 0 with value held deadbeef", cdb_valid, cdb_value);
    end
  endtask

  task automatic test_contention();
    int rob_nx[N];
    int exp_nx[N];
    logic [N-1:0] exp_rdy;
    int s;
    do_reset();
    for (int i = 0; i < N; i++) begin
      rob_nx[i] = i;
      exp_nx[i] = i;
    end
    for (int e = 1; e <= 10; e++) begin
      req_valid = '1;
      for (int i = 0; i < N; i++) begin
        req_rob_id[i] = RW'(rob_nx[i]);
        req_value[i]  = VW'(rob_nx[i] * 7 + 1);
        req_prd[i]    = PW'(rob_nx[i]);
      end
      #1;
      exp_rdy = (e == 1) ? 2'b11 : ((e % 2 == 0) ? 2'b01 : 2'b10);
      vectors++;
      if (req_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL contention_ready: cycle %0d req_ready=%b, want %b", e, req_ready, exp_rdy);
      end
      step();
      for (int i = 0; i < N; i++) if (exp_rdy[i]) rob_nx[i] += 2;
      if (e >= 2) begin
        s = e % 2;
        vectors++;
        if (cdb_valid !== 1'b1 || cdb_src !== SW'(s) || cdb_rob_id !== RW'(exp_nx[s])) begin
          miscompares++;
          $display("FAIL contention_bcast: edge %0d v=%b src=%0d rob=%0d, want 1/%0d/%0d",
                   e, cdb_valid, cdb_src, cdb_rob_id, s, exp_nx[s]);
        end
        exp_nx[s] += 2;
      end
    end
    req_valid = '0;
  endtask

  task automatic test_streaming();
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      req_valid = '0;
      if (e <= 8) begin
        req_valid[1]  = 1'b1;
        req_rob_id[1] = RW'(e - 1);
        req_value[1]  = VW'(32'h1000 + e);
        req_prd[1]    = PW'(e);
        #1;
        vectors++;
        if (req_ready[1] !== 1'b1) begin
          miscompares++;
          $display("FAIL stream_ready: cycle %0d req_ready[1]=%b, want 1", e, req_ready[1]);
        end
      end
      step();
      if (e >= 2 && e <= 9) begin
        vectors++;
        if (cdb_valid !== 1'b1 || cdb_rob_id !== RW'(e - 2) || cdb_src !== 1'b1) begin
          miscompares++;
          $display("FAIL stream_bcast: edge %0d v=%b rob=%0d src=%0d, want 1/%0d/1",
                   e, cdb_valid, cdb_rob_id, cdb_src, e - 2);
        end
      end else if (e == 10) begin
        vectors++;
        if (cdb_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL stream_end: cdb_valid=%b, want 0", cdb_valid);
        end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    req_valid     = 2'b01;
    req_rob_id[0] = 8'h10;
    step();
    req_valid     = 2'b11;
    req_rob_id[0] = 8'hA0;
    req_rob_id[1] = 8'hA1;
    #1;
    vectors++;
    if (req_ready !== 2'b11) begin
      miscompares++;
      $display("FAIL flush_fill_ready: req_ready=%b, want 11", req_ready);
    end
    step();
    req_valid = '0;
    vectors++;
    if (cdb_valid !== 1'b1 || cdb_rob_id !== 8'h10 || cdb_src !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_pre_bcast: v=%b rob=%h src=%0d, want 1/10/0", cdb_valid, cdb_rob_id, cdb_src);
    end
    flush = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_ready_low: req_ready=%b, want 00", req_ready);
    end
    step();
    flush = 1'b0;
    #1;
    vectors++;
    if (cdb_valid !== 1'b0 || req_ready !== 2'b11) begin
      miscompares++;
      $display("FAIL flush_after: v=%b req_ready=%b, want 0/11", cdb_valid, req_ready);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (cdb_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_no_ghost: idle %0d v=%b rob=%h, want no broadcast", k, cdb_valid, cdb_rob_id);
      end
    end
    req_valid     = 2'b11;
    req_rob_id[0] = 8'hB0;
    req_rob_id[1] = 8'hB1;
    step();
    req_valid = '0;
    step();
    vectors++;
    if (cdb_valid !== 1'b1 || cdb_src !== 1'b0 || cdb_rob_id !== 8'hB0) begin
      miscompares++;
      $display("FAIL flush_ptr_reset: v=%b src=%0d rob=%h, want 1/0/b0", cdb_valid, cdb_src, cdb_rob_id);
    end
    step();
    vectors++;
    if (cdb_valid !== 1'b1 || cdb_src !== 1'b1 || cdb_rob_id !== 8'hB1) begin
      miscompares++;
      $display("FAIL flush_second: v=%b src=%0d rob=%h, want 1/1/b1", cdb_valid, cdb_src, cdb_rob_id);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid     = 2'b11;
    req_rob_id[0] = 8'hC0;
    req_rob_id[1] = 8'hC1;
    step();
    req_valid = '0;
    step();
    vectors++;
    if (cdb_valid !== 1'b1 || cdb_rob_id !== 8'hC0) begin
      miscompares++;
      $display("FAIL async_pre: v=%b rob=%h, want 1/c0", cdb_valid, cdb_rob_id);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (cdb_valid !== 1'b0 || req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL async_assert: v=%b req_ready=%b before next edge, want 0/00", cdb_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if (cdb_valid !== 1'b0 || req_ready !== 2'b11) begin
        miscompares++;
        $display("FAIL async_quiet: idle %0d v=%b rob=%h rdy=%b, want 0/-/11",
                 k, cdb_valid, cdb_rob_id, req_ready);
      end
    end
  endtask

  task automatic test_random();
    logic          fu_hold[N];
    logic [PL-1:0] fu_pay[N];
    logic [N-1:0]  acc;
    logic [W-1:0]  tag;
    int            found;
    int            next_rob;
    int            n_cyc;
    do_reset();
    next_rob = 0;
    n_cyc    = 10000;
    for (int i = 0; i < N; i++) fu_hold[i] = 1'b0;
    for (int c = 0; c < n_cyc + 8; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!fu_hold[i] && c < n_cyc && $urandom_range(0, 2) != 0) begin
          fu_hold[i] = 1'b1;
          fu_pay[i]  = {RW'(next_rob), PW'($urandom_range(0, 63)), VW'($urandom)};
          next_rob++;
        end
        req_valid[i] = fu_hold[i];
        {req_rob_id[i], req_prd[i], req_value[i]} = fu_pay[i];
      end
      flush = (c < n_cyc) && ($urandom_range(0, 63) == 0);
      #1;
      acc = model_ready();
      vectors++;
      if (req_ready !== acc) begin
        miscompares++;
        $display("FAIL rand_ready: cycle %0d req_ready=%b, want %b", c, req_ready, acc);
      end
      for (int i = 0; i < N; i++) acc[i] = acc[i] & fu_hold[i];
      step();
      for (int i = 0; i < N; i++) if (flush || acc[i]) fu_hold[i] = 1'b0;
      vectors++;
      if (cdb_valid !== m_cv ||
          (m_cv && {cdb_src, cdb_rob_id, cdb_prd, cdb_value} !== m_cdb)) begin
        miscompares++;
        $display("FAIL rand_cdb: cycle %0d v=%b tag=%h, want v=%b tag=%h",
                 c, cdb_valid, {cdb_src, cdb_rob_id, cdb_prd, cdb_value}, m_cv, m_cdb);
      end
      if (cdb_valid === 1'b1) begin
        tag   = {cdb_src, cdb_rob_id, cdb_prd, cdb_value};
        found = -1;
        foreach (exp_q[j]) if (found < 0 && exp_q[j] === tag) found = j;
        vectors++;
        if (found < 0) begin
          miscompares++;
          $display("FAIL rand_sb_unknown: cycle %0d tag=%h not an outstanding result", c, tag);
        end else begin
          vectors++;
          if (cyc - acc_q[found] > N) begin
            miscompares++;
            $display("FAIL rand_fairness: tag=%h waited %0d edges, want <= %0d",
                     tag, cyc - acc_q[found], N);
          end
          exp_q.delete(found);
          acc_q.delete(found);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain: %0d accepted results never broadcast, want 0", exp_q.size());
    end
    clear_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_streaming();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
